// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, immediate/shift operand
// construction and load-use bubble insertion.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        id_valid,
  input  logic [3:0]  id_aluop,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_dest,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [15:0] id_imm,
  input  logic [4:0]  id_shamt,
  input  logic        id_src_b_imm,
  input  logic        id_imm_zext,
  input  logic        id_shift_imm,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        id_mem_write,
  input  logic        exmem_reg_write,
  input  logic [4:0]  exmem_rd,
  input  logic [31:0] exmem_result,
  input  logic        memwb_reg_write,
  input  logic [4:0]  memwb_rd,
  input  logic [31:0] memwb_result,
  output logic        ex_valid,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic [3:0]  ex_aluop,
  output logic [4:0]  ex_dest,
  output logic [31:0] ex_a,
  output logic [31:0] ex_b,
  output logic [31:0] ex_store_data,
  output logic        load_use
);

  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [15:0] imm;
  logic [4:0]  shamt;
  logic        src_b_imm;
  logic        imm_zext;
  logic        shift_imm;
  logic [31:0] fwd_rs;
  logic [31:0] fwd_rt;
  logic [31:0] imm_ext;

  // EX/MEM is the younger result, so it takes precedence; r0 is never forwarded.
  function automatic logic [31:0] forward(input logic [4:0] idx, input logic [31:0] reg_val);
    logic [31:0] val;
    val = reg_val;
    if (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == idx)
      val = exmem_result;
    else if (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == idx)
      val = memwb_result;
    return val;
  endfunction

  assign fwd_rs  = forward(rs, rs_data);
  assign fwd_rt  = forward(rt, rt_data);
  assign imm_ext = imm_zext ? {16'd0, imm} : {{16{imm[15]}}, imm};

  assign ex_a          = shift_imm ? {21'd0, shamt, 6'd0} : fwd_rs;
  assign ex_b          = src_b_imm ? imm_ext : fwd_rt;
  assign ex_store_data = fwd_rt;

  // rt is compared even when the ID instruction does not read it (conservative).
  assign load_use = ex_valid && ex_mem_read && (ex_dest != 5'd0) &&
                    ((ex_dest == id_rs) || (ex_dest == id_rt)) && id_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_aluop     <= 4'd0;
      ex_dest      <= 5'd0;
      rs           <= 5'd0;
      rt           <= 5'd0;
      rs_data      <= 32'd0;
      rt_data      <= 32'd0;
      imm          <= 16'd0;
      shamt        <= 5'd0;
      src_b_imm    <= 1'b0;
      imm_zext     <= 1'b0;
      shift_imm    <= 1'b0;
    end else if (stall) begin
      // Capture forwarded values so a result retiring during the stall survives.
      rs_data <= fwd_rs;
      rt_data <= fwd_rt;
    end else if (flush || load_use) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_aluop     <= 4'd0;
      ex_dest      <= 5'd0;
      rs           <= 5'd0;
      rt           <= 5'd0;
      rs_data      <= 32'd0;
      rt_data      <= 32'd0;
      imm          <= 16'd0;
      shamt        <= 5'd0;
      src_b_imm    <= 1'b0;
      imm_zext     <= 1'b0;
      shift_imm    <= 1'b0;
    end else begin
      ex_valid     <= id_valid;
      ex_reg_write <= id_reg_write;
      ex_mem_read  <= id_mem_read;
      ex_mem_write <= id_mem_write;
      ex_aluop     <= id_aluop;
      ex_dest      <= id_dest;
      rs           <= id_rs;
      rt           <= id_rt;
      rs_data      <= id_rs_data;
      rt_data      <= id_rt_data;
      imm          <= id_imm;
      shamt        <= id_shamt;
      src_b_imm    <= id_src_b_imm;
      imm_zext     <= id_imm_zext;
      shift_imm    <= id_shift_imm;
    end
  end

endmodule
